// File: rtl/sqrt_unit.sv
// Iterative restoring integer square root, one root bit per clock (IDLE, LOAD, 16x ITER, DONE).
// Optional macro SQRT_ROUND_EN selects round-to-nearest (saturating) instead of the floor root.
module sqrt_unit #(
  parameter int DIN_W  = 32,
  parameter int DOUT_W = DIN_W / 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIN_W-1:0]  din,
  output logic [DOUT_W-1:0] dout,
  output logic [3:0]        cstate,
  output logic              valid
);

  localparam int REM_W = DIN_W / 2 + 2;
  localparam int CNT_W = $clog2(DOUT_W + 1);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LOAD = 4'd1,
    ITER = 4'd2,
    DONE = 4'd3
  } state_t;

  state_t              state, state_nxt;
  logic [DIN_W-1:0]    rad;
  logic [REM_W-1:0]    rem;
  logic [DOUT_W-1:0]   root;
  logic [CNT_W-1:0]    cnt;

  logic [REM_W+1:0]    rem_sh;
  logic [REM_W+1:0]    trial;
  logic                ge;
  logic [REM_W-1:0]    rem_it;
  logic [DOUT_W-1:0]   root_it;
  logic [DOUT_W-1:0]   dout_nxt;

  // The shifted remainder is two bits wider than rem; after subtraction it fits rem again.
  assign rem_sh  = {rem, rad[DIN_W-1 -: 2]};
  assign trial   = {{(REM_W - DOUT_W){1'b0}}, root, 2'b01};
  assign ge      = (rem_sh >= trial);
  assign rem_it  = ge ? REM_W'(rem_sh - trial) : REM_W'(rem_sh);
  assign root_it = {root[DOUT_W-2:0], ge};

`ifdef SQRT_ROUND_EN
  // x - r^2 > r  <=>  sqrt(x) >= r + 0.5
  always_comb begin
    dout_nxt = root_it;
    if ((rem_it > REM_W'(root_it)) && !(&root_it))
      dout_nxt = root_it + 1'b1;
  end
`else
  assign dout_nxt = root_it;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = LOAD;
      LOAD:    state_nxt = ITER;
      ITER:    state_nxt = (cnt == '0) ? DONE : ITER;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (enable) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rad  <= '0;
      rem  <= '0;
      root <= '0;
      cnt  <= '0;
      dout <= '0;
    end else if (enable) begin
      case (state)
        IDLE: rad <= din;
        LOAD: begin
          rem  <= '0;
          root <= '0;
          cnt  <= CNT_W'(DOUT_W - 1);
        end
        ITER: begin
          rad  <= rad << 2;
          rem  <= rem_it;
          root <= root_it;
          // dout is loaded as DONE is entered so it is valid alongside the DONE state.
          if (cnt == '0) dout <= dout_nxt;
          else           cnt  <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cstate = state;
  assign valid  = (state == DONE);

endmodule

// File: tb/tb_sqrt_unit.sv
// Directed vector bench for sqrt_unit: reset, FSM sequence, floor/rounded results, stall, mid-run reset.
module tb_sqrt_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [31:0] din = 32'd0;
  logic [15:0] dout;
  logic [3:0]  cstate;
  logic        valid;

  int n_chk  = 0;
  int n_fail = 0;

  sqrt_unit dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .din    (din),
    .dout   (dout),
    .cstate (cstate),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [15:0] r_floor;
    logic [15:0] r_round;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [15:0] pick(input vec_t v);
`ifdef SQRT_ROUND_EN
    return v.r_round;
`else
    return v.r_floor;
`endif
  endfunction

  // Waits for IDLE, presents x, then scrambles din after it has been sampled.
  // Valid is expected on negedge 18 after the sampling edge (LOAD + 16 ITER + DONE),
  // plus one negedge per stalled cycle.
  task automatic run(input string name, input logic [31:0] x, input logic [15:0] exp,
                     input int stall_at, input int stall_len);
    int n;
    bit found;
    logic [15:0] dout_snap;
    logic [3:0]  cs_snap;
    n = 0;
    found = 0;
    while (cstate != 4'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    din = x;
    n = 0;
    while (!found && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) din = ~x;
      if (stall_len > 0) begin
        if (n == stall_at) begin
          enable    = 1'b0;
          dout_snap = dout;
          cs_snap   = cstate;
        end else if (n > stall_at && n <= stall_at + stall_len) begin
          chk({name, " stall cstate"}, cstate, cs_snap);
          chk({name, " stall dout"}, dout, dout_snap);
          if (n == stall_at + stall_len) enable = 1'b1;
        end
      end
      if (valid) found = 1;
    end
    if (!found) begin
      chk({name, " timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, " latency"}, n, 18 + stall_len);
      chk({name, " dout"}, dout, exp);
      @(negedge clk);
      chk({name, " valid pulse width"}, valid, 1'b0);
    end
  endtask

  initial begin
    logic [3:0] exp_cs;

    vecs[0]  = '{32'd16,         16'd4,     16'd4};
    vecs[1]  = '{32'd1000000,    16'd1000,  16'd1000};
    vecs[2]  = '{32'd2,          16'd1,     16'd1};
    vecs[3]  = '{32'd3,          16'd1,     16'd2};
    vecs[4]  = '{32'hFFFFFFFF,   16'd65535, 16'd65535};
    vecs[5]  = '{32'd12,         16'd3,     16'd3};
    vecs[6]  = '{32'd13,         16'd3,     16'd4};
    vecs[7]  = '{32'd144,        16'd12,    16'd12};
    vecs[8]  = '{32'd0,          16'd0,     16'd0};
    vecs[9]  = '{32'd1,          16'd1,     16'd1};
    vecs[10] = '{32'd999999,     16'd999,   16'd1000};
    vecs[11] = '{32'hFFFE0001,   16'd65535, 16'd65535};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset cstate", cstate, 4'd0);
    chk("reset valid", valid, 1'b0);
    chk("reset dout", dout, 16'd0);

    // Free-running with din=0: two full 19-cycle periods of the state sequence
    reset = 1'b0;
    for (int k = 0; k < 38; k++) begin
      if (k > 0) @(negedge clk);
      case (k % 19)
        0:       exp_cs = 4'd0;
        1:       exp_cs = 4'd1;
        18:      exp_cs = 4'd3;
        default: exp_cs = 4'd2;
      endcase
      chk($sformatf("seq cstate k=%0d", k), cstate, exp_cs);
      chk($sformatf("seq valid k=%0d", k), valid, (exp_cs == 4'd3));
      chk($sformatf("seq dout k=%0d", k), dout, 16'd0);
    end

    for (int i = 0; i < 12; i++)
      run($sformatf("vec%0d x=%0d", i, vecs[i].x), vecs[i].x, pick(vecs[i]), 0, 0);

    // Stall for 5 cycles mid-ITER
    run("stall 1000000", 32'd1000000, 16'd1000, 5, 5);

    // Reset in the middle of ITER aborts and clears the previous result
    run("pre-reset 65535^2", 32'hFFFE0001, 16'd65535, 0, 0);
    din = 32'd1000000;
    repeat (9) @(negedge clk);
    chk("mid-run cstate before reset", cstate, 4'd2);
    reset = 1'b1;
    #1;
    chk("mid-run reset cstate", cstate, 4'd0);
    chk("mid-run reset valid", valid, 1'b0);
    chk("mid-run reset dout", dout, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    run("after reset 144", 32'd144, 16'd12, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
